// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared parameters, address type and helpers for the register file
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  function automatic int addr_w(input int nreg);
    return $clog2(nreg);
  endfunction
  typedef logic [addr_w(DEF_NREG)-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, alloc and writeback bundle between core and register file
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  localparam int AW = addr_w(NREG);
  logic [NRD-1:0]      i_rs_ren;
  logic [NRD*AW-1:0]   i_rs_raddr;
  logic [NRD*XLEN-1:0] o_rs_rdata;
  logic [NRD-1:0]      o_rs_busy;
  logic                i_rd_alloc;
  logic [AW-1:0]       i_rd_alloc_addr;
  logic [NWR-1:0]      i_rd_wvalid;
  logic [NWR*AW-1:0]   i_rd_waddr;
  logic [NWR*XLEN-1:0] i_rd_wdata;
  modport master (
    output i_rs_ren, i_rs_raddr, i_rd_alloc, i_rd_alloc_addr, i_rd_wvalid, i_rd_waddr, i_rd_wdata,
    input  o_rs_rdata, o_rs_busy
  );
  modport slave (
    input  i_rs_ren, i_rs_raddr, i_rd_alloc, i_rd_alloc_addr, i_rd_wvalid, i_rd_waddr, i_rd_wdata,
    output o_rs_rdata, o_rs_busy
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register busy bits, alloc sets, writeback clears, alloc wins a tie
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int NWR  = 1,
  localparam int AW  = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alloc,
  input  logic [AW-1:0]     i_alloc_addr,
  input  logic [NWR-1:0]    i_wvalid,
  input  logic [NWR*AW-1:0] i_waddr,
  output logic [NREG-1:0]   o_busy,
  output logic [NREG-1:0]   o_busy_nxt
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  // decode alloc and writeback strobes; x0 can never become busy
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_alloc) w_set[i_alloc_addr] = 1'b1;
    for (int w = 0; w < NWR; w++)
      if (i_wvalid[w]) w_clr[i_waddr[w*AW +: AW]] = 1'b1;
    o_busy_nxt = ((r_busy & ~w_clr) | w_set) & {{(NREG-1){1'b1}}, 1'b0};
  end
  // busy vector state
  always_ff @(posedge clk or posedge rst)
    if (rst) r_busy <= '0;
    else r_busy <= o_busy_nxt;
  assign o_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired, optional write bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  regfile_mp_if.slave bus
);
  localparam int AW = addr_w(NREG);
  localparam logic [AW-1:0] A_ZERO = AW'(REG_ZERO);
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_busy_nxt;
  regfile_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_alloc      (bus.i_rd_alloc),
    .i_alloc_addr (bus.i_rd_alloc_addr),
    .i_wvalid     (bus.i_rd_wvalid),
    .i_waddr      (bus.i_rd_waddr),
    .o_busy       (w_busy),
    .o_busy_nxt   (w_busy_nxt)
  );
  // writeback; later ports are applied last so the higher index wins a collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (bus.i_rd_wvalid[w] && bus.i_rd_waddr[w*AW +: AW] != A_ZERO)
          r_mem[bus.i_rd_waddr[w*AW +: AW]] <= bus.i_rd_wdata[w*XLEN +: XLEN];
    end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;
    logic [XLEN-1:0] r_data;
    logic            r_bsy;
    assign w_a = bus.i_rs_raddr[p*AW +: AW];
    // find the highest-indexed same-cycle write to this read address
    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int w = 0; w < NWR; w++)
        if (bus.i_rd_wvalid[w] && bus.i_rd_waddr[w*AW +: AW] == w_a) begin
          w_hit = 1'b1;
          w_fwd = bus.i_rd_wdata[w*XLEN +: XLEN];
        end
    end
    // registered read; forwarded reads report the post-edge busy state
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_data <= '0;
        r_bsy  <= 1'b0;
      end else if (bus.i_rs_ren[p]) begin
        r_data <= (w_a == A_ZERO) ? '0 : (BYPASS != 0 && w_hit) ? w_fwd : r_mem[w_a];
        r_bsy  <= (w_a == A_ZERO) ? 1'b0 : (BYPASS != 0 && w_hit) ? w_busy_nxt[w_a] : w_busy[w_a];
      end
    assign bus.o_rs_rdata[p*XLEN +: XLEN] = r_data;
    assign bus.o_rs_busy[p] = r_bsy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of reset, x0, read/hold, bypass, scoreboard and port independence
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]  ren = '0;
  logic [19:0] raddr = '0;
  logic        alloc = 1'b0;
  logic [4:0]  alloc_addr = '0;
  logic [1:0]  wvalid = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  regfile_mp_if #(.NRD(4), .NWR(2)) if0 ();
  regfile_mp_if #(.NRD(4), .NWR(2)) if1 ();
  assign if0.i_rs_ren = ren;
  assign if0.i_rs_raddr = raddr;
  assign if0.i_rd_alloc = alloc;
  assign if0.i_rd_alloc_addr = alloc_addr;
  assign if0.i_rd_wvalid = wvalid;
  assign if0.i_rd_waddr = waddr;
  assign if0.i_rd_wdata = wdata;
  assign if1.i_rs_ren = ren;
  assign if1.i_rs_raddr = raddr;
  assign if1.i_rd_alloc = alloc;
  assign if1.i_rd_alloc_addr = alloc_addr;
  assign if1.i_rd_wvalid = wvalid;
  assign if1.i_rd_waddr = waddr;
  assign if1.i_rd_wdata = wdata;
  regfile_mp #(.NRD(4), .NWR(2), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_mp #(.NRD(4), .NWR(2), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    ren = '0;
    wvalid = '0;
    alloc = 1'b0;
  endtask
  task automatic wr(input int w, input int a, input logic [31:0] d);
    wvalid[w] = 1'b1;
    waddr[w*5 +: 5] = 5'(a);
    wdata[w*32 +: 32] = d;
  endtask
  task automatic rd(input int p, input int a);
    ren[p] = 1'b1;
    raddr[p*5 +: 5] = 5'(a);
  endtask
  function automatic logic [31:0] d0(input int p);
    return if0.o_rs_rdata[p*32 +: 32];
  endfunction
  function automatic logic [31:0] d1(input int p);
    return if1.o_rs_rdata[p*32 +: 32];
  endfunction
  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_rdata", if0.o_rs_rdata[31:0], 32'h0);
    check("reset_busy", {28'h0, if0.o_rs_busy}, 32'h0);
    rst = 1'b0;
    wr(0, 5, 32'hDEADBEEF); tick();
    rd(0, 5); tick();
    check("x5_before_reset", d0(0), 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_rdata", d0(0), 32'h0);
    rst = 1'b0;
    rd(0, 5); tick();
    check("x5_after_reset", d0(0), 32'h0);
    wr(0, 0, 32'h12345678); alloc = 1'b1; alloc_addr = 5'd0; tick();
    rd(0, 0); rd(1, 0); tick();
    check("x0_p0_data", d0(0), 32'h0);
    check("x0_p1_data", d0(1), 32'h0);
    check("x0_busy", {30'h0, if0.o_rs_busy[1:0]}, 32'h0);
    wr(0, 3, 32'hA5A5A5A5); tick();
    rd(0, 3); tick();
    check("x3_read", d0(0), 32'hA5A5A5A5);
    raddr[4:0] = 5'd4; tick();
    check("x3_hold", d0(0), 32'hA5A5A5A5);
    wr(0, 7, 32'h5); tick();
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); tick();
    check("bypass_hi_port", d0(0), 32'h22);
    check("bypass_busy", {31'h0, if0.o_rs_busy[0]}, 32'h0);
    check("nobypass_old", d1(0), 32'h5);
    rd(0, 7); tick();
    check("x7_array_b1", d0(0), 32'h22);
    check("x7_array_b0", d1(0), 32'h22);
    alloc = 1'b1; alloc_addr = 5'd9; tick();
    rd(0, 9); tick();
    check("alloc_busy", {31'h0, if0.o_rs_busy[0]}, 32'h1);
    wr(0, 9, 32'h55); tick();
    rd(0, 9); tick();
    check("wb_data", d0(0), 32'h55);
    check("wb_busy", {31'h0, if0.o_rs_busy[0]}, 32'h0);
    alloc = 1'b1; alloc_addr = 5'd9; wr(0, 9, 32'h66); tick();
    rd(0, 9); tick();
    check("alloc_wb_data", d0(0), 32'h66);
    check("alloc_wb_busy", {31'h0, if0.o_rs_busy[0]}, 32'h1);
    wr(1, 9, 32'h77); rd(0, 9); tick();
    check("fwd_clear_data", d0(0), 32'h77);
    check("fwd_clear_busy", {31'h0, if0.o_rs_busy[0]}, 32'h0);
    check("nofwd_data", d1(0), 32'h66);
    check("nofwd_busy", {31'h0, if1.o_rs_busy[0]}, 32'h1);
    alloc = 1'b1; alloc_addr = 5'd9; wr(0, 9, 32'h88); rd(0, 9); tick();
    check("fwd_alloc_data", d0(0), 32'h88);
    check("fwd_alloc_busy", {31'h0, if0.o_rs_busy[0]}, 32'h1);
    wr(0, 1, 32'h1); wr(1, 2, 32'h2); tick();
    wr(0, 3, 32'h3); wr(1, 4, 32'h4); tick();
    for (int p = 0; p < 4; p++) rd(p, p + 1);
    tick();
    for (int p = 0; p < 4; p++) check($sformatf("port%0d_read", p), d0(p), 32'(p + 1));
    raddr = {5'd1, 5'd1, 5'd1, 5'd4}; ren = 4'b0001; tick();
    check("port0_new", d0(0), 32'h4);
    for (int p = 1; p < 4; p++) check($sformatf("port%0d_hold", p), d0(p), 32'(p + 1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
